// File: rtl/reset_sequencer.sv
// Board bring-up reset sequencer: waits for stable PLL lock, then
// releases reset domains in index order; re-sequences on loss or button.
module reset_sequencer #(
  parameter int NUM_LOCK        = 1,
  parameter int NUM_STAGES      = 3,
  parameter int LOCK_STABLE     = 1024,
  parameter int STAGE_DELAY     = 256,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_LOCK-1:0]   locked_i,
  input  logic                  button_i,
  output logic [NUM_STAGES-1:0] rst_stage_o,
  output logic                  ready_o,
  output logic [1:0]            state_o,
  output logic [7:0]            lock_loss_cnt_o
);

  localparam int CMAX =
    (LOCK_STABLE > STAGE_DELAY) ? LOCK_STABLE : STAGE_DELAY;
  localparam int CW = $clog2(CMAX + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] LS_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] SD_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_STAGES - 1);
  localparam logic [IW-1:0] I_ONE   = IW'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [NUM_LOCK-1:0]    lock_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   lock_ok;
  logic                   btn_s;

  logic [DW-1:0]          db_cnt;
  logic                   db_lvl;
  logic                   btn_req;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [NUM_STAGES-1:0]  rst_stage;
  logic                   ready;
  logic [7:0]             llc;
  logic                   abort_lock;

  // Bring the async lock flags and button into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        lock_sync[i] <= '0;
      btn_sync <= '0;
    end else begin
      lock_sync[0] <= locked_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        lock_sync[i] <= lock_sync[i-1];
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], button_i};
    end
  end

  assign lock_ok = &lock_sync[SYNC_STAGES-1];
  assign btn_s   = btn_sync[SYNC_STAGES-1];

  // Debounce the button; a press yields a one-cycle request pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt  <= '0;
      db_lvl  <= 1'b0;
      btn_req <= 1'b0;
    end else begin
      btn_req <= 1'b0;
      if (btn_s != db_lvl) begin
        if (db_cnt == DB_LAST) begin
          db_lvl  <= btn_s;
          db_cnt  <= '0;
          btn_req <= btn_s;
        end else begin
          db_cnt <= db_cnt + DB_ONE;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Lock loss only matters once the sequence has started
  assign abort_lock = !lock_ok && (state != WAIT_LOCK);

  // Sequencing FSM with registered stage resets, ready and loss count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      idx       <= '0;
      rst_stage <= '1;
      ready     <= 1'b0;
      llc       <= '0;
    end else if (abort_lock || btn_req) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      idx       <= '0;
      rst_stage <= '1;
      ready     <= 1'b0;
      if (abort_lock && state == RUN && llc != 8'hFF)
        llc <= llc + 8'd1;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          if (lock_ok) begin
            state <= STABLE;
            cnt   <= '0;
          end
        end
        STABLE: begin
          if (cnt == LS_LAST) begin
            rst_stage[0] <= 1'b0;
            cnt          <= '0;
            idx          <= I_ONE;
            if (NUM_STAGES == 1) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        RELEASE: begin
          if (cnt == SD_LAST) begin
            rst_stage[idx] <= 1'b0;
            cnt            <= '0;
            if (idx == I_LAST) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              idx <= idx + I_ONE;
            end
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        RUN: begin
        end
      endcase
    end
  end

  assign rst_stage_o     = rst_stage;
  assign ready_o         = ready;
  assign state_o         = state;
  assign lock_loss_cnt_o = llc;

endmodule
